// File: rtl/cnt_bcd_pkg.sv
// ============================================================================
// Module      : cnt_bcd_pkg
// Description : Shared definitions for the multi-digit BCD counter: FSM state
//               encodings, the largest legal BCD digit and a nibble check.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cnt_bcd_pkg;

    // Controller states; the unused encoding 2'd3 recovers to INIT.
    typedef enum logic [1:0] {
        INIT  = 2'd0,
        COUNT = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // True when the nibble is a legal decimal digit.
    function automatic logic bcd_valid(input logic [3:0] nib);
        return (nib <= BCD_MAX);
    endfunction

endpackage

`default_nettype wire

// File: rtl/cnt_bcd_multi_if.sv
// ============================================================================
// Module      : cnt_bcd_multi_if
// Description : Control/status bundle of the BCD counter.
//               master : drives en, load, din (and up)
//               slave  : drives Q, tc, err, state_o
//               Port 'up' only exists when CNT_BCD_DOWN_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cnt_bcd_multi_if #(
    parameter int NDIG = 4
);
    logic                en;
    logic                load;
    logic [4*NDIG-1:0]   din;
`ifdef CNT_BCD_DOWN_EN
    logic                up;
`endif
    logic [4*NDIG-1:0]   Q;
    logic                tc;
    logic                err;
    logic [1:0]          state_o;

`ifdef CNT_BCD_DOWN_EN
    modport master (output en, load, din, up, input Q, tc, err, state_o);
    modport slave  (input en, load, din, up, output Q, tc, err, state_o);
`else
    modport master (output en, load, din, input Q, tc, err, state_o);
    modport slave  (input en, load, din, output Q, tc, err, state_o);
`endif
endinterface

`default_nettype wire

// File: rtl/bcd_digit.sv
// ============================================================================
// Module      : bcd_digit
// Description : One decade of the ripple chain. With ci=1 the digit steps up
//               (dir=1, 9 -> 0 with carry) or down (dir=0, 0 -> 9 with
//               borrow); with ci=0 it holds.
// Ports       : digit_i (current digit), ci, dir -> next_o (next digit), co
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_digit
    import cnt_bcd_pkg::*;
(
    input  wire logic [3:0] digit_i,
    input  wire logic       ci,
    input  wire logic       dir,
    output logic      [3:0] next_o,
    output logic            co
);

    always_comb begin
        next_o = digit_i;
        co     = 1'b0;
        if (ci) begin
            if (dir) begin
                if (digit_i >= BCD_MAX) begin
                    next_o = 4'd0;
                    co     = 1'b1;
                end else begin
                    next_o = digit_i + 4'd1;
                end
            end else begin
                if (digit_i == 4'd0) begin
                    next_o = BCD_MAX;
                    co     = 1'b1;
                end else begin
                    next_o = digit_i - 4'd1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/cnt_bcd_multi.sv
// ============================================================================
// Module      : cnt_bcd_multi
// Description : NDIG-digit BCD counter with terminal value NSTOP, parallel
//               load with digit validation and an INIT/COUNT/PAUSE controller.
//               Optional down counting is enabled by the macro CNT_BCD_DOWN_EN.
// Ports       : clock - rising-edge clock
//               reset - asynchronous, active-low
//               bus   - cnt_bcd_multi_if.slave (en, load, din, [up] in;
//                       Q, tc, err, state_o out)
// Parameters  : NDIG  (1..8), NSTOP (BCD terminal value, every nibble 0..9)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cnt_bcd_multi
    import cnt_bcd_pkg::*;
#(
    parameter int                  NDIG  = 4,
    parameter logic [4*NDIG-1:0]   NSTOP = {NDIG{4'h9}}
) (
    input  wire logic        clock,
    input  wire logic        reset,
    cnt_bcd_multi_if.slave   bus
);

    localparam int W = 4 * NDIG;

    state_t         state_q, state_d;
    logic [W-1:0]   q_q, q_d;
    logic           err_q, err_d;

    logic           w_dir;
    logic [W-1:0]   w_step;
    logic [NDIG-1:0] w_ci;
    logic [NDIG-1:0] w_co;
    logic [NDIG-1:0] w_nib_ok;
    logic           w_load_ok;
    logic           w_term;
    logic [W-1:0]   w_wrap;
    logic           w_unused_co;

    // Without the down option the direction is a constant, so the borrow
    // half of every digit folds away.
`ifdef CNT_BCD_DOWN_EN
    assign w_dir = bus.up;
`else
    assign w_dir = 1'b1;
`endif

    // Decimal ripple chain; the least significant digit always steps.
    for (genvar g = 0; g < NDIG; g++) begin : g_digit
        if (g == 0) begin : g_lsd
            assign w_ci[g] = 1'b1;
        end else begin : g_upper
            assign w_ci[g] = w_co[g-1];
        end

        bcd_digit u_digit (
            .digit_i (q_q[4*g +: 4]),
            .ci      (w_ci[g]),
            .dir     (w_dir),
            .next_o  (w_step[4*g +: 4]),
            .co      (w_co[g])
        );

        assign w_nib_ok[g] = bcd_valid(bus.din[4*g +: 4]);
    end

    // Carry out of the top digit is the natural all-9s (or all-0s) wrap.
    assign w_unused_co = w_co[NDIG-1];
    assign w_load_ok   = &w_nib_ok;

    // Terminal value and wrap target depend on direction.
    assign w_term = w_dir ? (q_q == NSTOP) : (q_q == '0);
    assign w_wrap = w_dir ? '0 : NSTOP;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= INIT;
            q_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        err_d   = 1'b0;
        case (state_q)
            INIT: begin
                q_d     = '0;
                state_d = COUNT;
            end
            COUNT: begin
                if (bus.load) begin
                    // A rejected load leaves Q alone and flags the error.
                    if (w_load_ok) q_d   = bus.din;
                    else           err_d = 1'b1;
                end else if (bus.en) begin
                    q_d = w_term ? w_wrap : w_step;
                end else begin
                    state_d = PAUSE;
                end
            end
            PAUSE: begin
                if (bus.load) begin
                    if (w_load_ok) q_d   = bus.din;
                    else           err_d = 1'b1;
                end else if (bus.en) begin
                    // Resume only; the first step happens on the next edge.
                    state_d = COUNT;
                end
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    assign bus.Q       = q_q;
    assign bus.err     = err_q;
    assign bus.state_o = state_q;
    assign bus.tc      = (state_q == COUNT) && bus.en && !bus.load && w_term;

endmodule

`default_nettype wire

// File: tb/tb_cnt_bcd_multi.sv
// ============================================================================
// Module      : tb_cnt_bcd_multi
// Description : Directed self-checking bench. Instance A: NDIG=2, NSTOP=59.
//               Instance B: NDIG=4, default NSTOP=9999. Down-count steps run
//               only when CNT_BCD_DOWN_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cnt_bcd_multi;

    logic clock;
    logic reset;
    int   n_cmp;
    int   n_bad;

    cnt_bcd_multi_if #(.NDIG(2)) ifa ();
    cnt_bcd_multi_if #(.NDIG(4)) ifb ();

    cnt_bcd_multi #(.NDIG(2), .NSTOP(8'h59)) u_a (
        .clock (clock),
        .reset (reset),
        .bus   (ifa)
    );

    cnt_bcd_multi #(.NDIG(4)) u_b (
        .clock (clock),
        .reset (reset),
        .bus   (ifb)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] bcd2(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset    = 1'b0;
        ifa.en   = 1'b0; ifa.load = 1'b0; ifa.din = '0;
        ifb.en   = 1'b0; ifb.load = 1'b0; ifb.din = '0;
`ifdef CNT_BCD_DOWN_EN
        ifa.up = 1'b1;
        ifb.up = 1'b1;
`endif
        #3;
        // Reset state
        check("rst_a_q",     ifa.Q,       0);
        check("rst_a_state", ifa.state_o, 0);
        check("rst_a_err",   ifa.err,     0);
        check("rst_a_tc",    ifa.tc,      0);
        check("rst_b_q",     ifb.Q,       0);
        tick();
        check("rst_hold_state", ifa.state_o, 0);

        // Free-running count 00..59 then wrap, tc only at 59
        ifa.en = 1'b1;
        reset  = 1'b1;
        #1;
        check("init_state", ifa.state_o, 0);
        check("init_tc",    ifa.tc,      0);
        for (int n = 1; n <= 66; n++) begin
            tick();
            check("run_q",  ifa.Q,  bcd2((n - 1) % 60));
            check("run_tc", ifa.tc, ((n - 1) % 60) == 59);
            if (n == 1) check("run_state", ifa.state_o, 1);
        end
        check("b_idle_state", ifb.state_o, 2);
        check("b_idle_q",     ifb.Q,       0);

        // en toggle 1,0,1 at Q=05
        ifa.en = 1'b0;
        tick();
        check("pause_state", ifa.state_o, 2);
        check("pause_q",     ifa.Q,       8'h05);
        ifa.en = 1'b1;
        tick();
        check("resume_state", ifa.state_o, 1);
        check("resume_q",     ifa.Q,       8'h05);
        tick();
        check("step_q", ifa.Q, 8'h06);

        // Invalid load
        ifa.load = 1'b1; ifa.din = 8'h3A;
        tick();
        check("badld_q",     ifa.Q,       8'h06);
        check("badld_err",   ifa.err,     1);
        check("badld_state", ifa.state_o, 1);
        ifa.load = 1'b0; ifa.en = 1'b0;
        tick();
        check("badld_err_clr", ifa.err,     0);
        check("badld_q2",      ifa.Q,       8'h06);
        check("badld_state2",  ifa.state_o, 2);

        // Valid load in PAUSE, then count to NSTOP
        ifa.load = 1'b1; ifa.din = 8'h58;
        tick();
        check("pld_q",     ifa.Q,       8'h58);
        check("pld_state", ifa.state_o, 2);
        check("pld_err",   ifa.err,     0);
        ifa.load = 1'b0; ifa.en = 1'b1;
        tick();
        check("pld_resume_state", ifa.state_o, 1);
        check("pld_resume_q",     ifa.Q,       8'h58);
        check("tc_58",            ifa.tc,      0);
        tick();
        check("q_59",  ifa.Q,  8'h59);
        check("tc_59", ifa.tc, 1);
        ifa.load = 1'b1; ifa.din = 8'h12;
        #1;
        check("tc_59_load", ifa.tc, 0);
        tick();
        check("cld_q",     ifa.Q,       8'h12);
        check("cld_state", ifa.state_o, 1);

        // Load above NSTOP runs through the decimal chain to 99 -> 00
        ifa.din = 8'h97;
        tick();
        check("hi_q97", ifa.Q, 8'h97);
        ifa.load = 1'b0;
        tick();
        check("hi_q98", ifa.Q, 8'h98);
        tick();
        check("hi_q99",  ifa.Q,  8'h99);
        check("hi_tc99", ifa.tc, 0);
        tick();
        check("hi_q00", ifa.Q, 8'h00);
        tick();
        check("hi_q01", ifa.Q, 8'h01);

        // Reset mid-count at Q=37 with err pending
        ifa.load = 1'b1; ifa.din = 8'h35;
        tick();
        ifa.load = 1'b0;
        tick();
        tick();
        check("pre_rst_q", ifa.Q, 8'h37);
        ifa.load = 1'b1; ifa.din = 8'h3A;
        tick();
        check("pre_rst_err", ifa.err, 1);
        ifa.load = 1'b0;
        reset = 1'b0;
        #1;
        check("async_q",     ifa.Q,       0);
        check("async_err",   ifa.err,     0);
        check("async_state", ifa.state_o, 0);
        check("async_tc",    ifa.tc,      0);
        tick();
        check("rst_held_q", ifa.Q, 0);
        reset = 1'b1;
        #1;
        check("rel_state", ifa.state_o, 0);
        tick();
        check("rel_state2", ifa.state_o, 1);
        check("rel_q0",     ifa.Q,       8'h00);
        tick();
        check("rel_q1", ifa.Q, 8'h01);
        tick();
        check("rel_q2", ifa.Q, 8'h02);
        ifa.en = 1'b0;

        // Four-digit carry through three digits
        ifb.load = 1'b1; ifb.din = 16'h0999;
        tick();
        check("b_ld_q",     ifb.Q,       16'h0999);
        check("b_ld_state", ifb.state_o, 2);
        ifb.load = 1'b0; ifb.en = 1'b1;
        tick();
        check("b_res_state", ifb.state_o, 1);
        check("b_res_q",     ifb.Q,       16'h0999);
        tick();
        check("b_carry_q", ifb.Q, 16'h1000);

        // Default terminal value 9999
        ifb.load = 1'b1; ifb.din = 16'h9999;
        tick();
        ifb.load = 1'b0;
        #1;
        check("b_q9999",  ifb.Q,  16'h9999);
        check("b_tc9999", ifb.tc, 1);
        tick();
        check("b_wrap_q", ifb.Q,  16'h0000);
        check("b_tc0",    ifb.tc, 0);
        ifb.load = 1'b1; ifb.din = 16'hA123;
        tick();
        check("b_badld_q",   ifb.Q,   16'h0000);
        check("b_badld_err", ifb.err, 1);
        ifb.load = 1'b0;
        tick();
        check("b_after_q",   ifb.Q,   16'h0001);
        check("b_after_err", ifb.err, 0);

`ifdef CNT_BCD_DOWN_EN
        // Down count from 10 through 00 and wrap to NSTOP
        ifa.en = 1'b1;
        tick();
        ifa.up = 1'b0; ifa.load = 1'b1; ifa.din = 8'h10;
        tick();
        check("dn_ld_q", ifa.Q, 8'h10);
        ifa.load = 1'b0;
        for (int k = 9; k >= 0; k--) begin
            tick();
            #1;
            check("dn_q",  ifa.Q,  bcd2(k));
            check("dn_tc", ifa.tc, k == 0);
        end
        tick();
        check("dn_wrap_q",  ifa.Q,  8'h59);
        check("dn_wrap_tc", ifa.tc, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cnt_bcd_multi.md
CNT_BCD_MULTI -- requirements
Module: cnt_bcd_multi

Interface
REQ-001 Parameter NDIG, default 4: number of BCD digits, 1..8.
REQ-002 Parameter NSTOP, default all-9s (4*NDIG bits, BCD): terminal value; every nibble SHALL be 0..9.
REQ-003 Port clock  input  1  rising-edge clock.
REQ-004 Port reset  input  1  reset, asynchronous, active-low.
REQ-005 Port en  input  1  count enable.
REQ-006 Port load  input  1  synchronous parallel load request.
REQ-007 Port din  input  4*NDIG  BCD load value, digit 0 in bits [3:0].
REQ-008 Port up  input  1  direction, 1=up, 0=down; present only with CNT_BCD_DOWN_EN.
REQ-009 Port Q  output  4*NDIG  current BCD count.
REQ-010 Port tc  output  1  terminal-count pulse (combinational).
REQ-011 Port err  output  1  invalid-load flag, registered, one cycle.
REQ-012 Port state_o  output  2  current FSM state.

Function
REQ-013 FSM states: INIT (2'd0), COUNT (2'd1), PAUSE (2'd2); 2'd3 SHALL go to INIT on the next edge.
REQ-014 INIT: Q forced to 0; next state is COUNT unconditionally; load and en are ignored.
REQ-015 COUNT: en=1 steps Q on the edge; en=0 moves to PAUSE with Q held.
REQ-016 PAUSE: Q held; en=1 moves to COUNT on that edge, no step on that edge.
REQ-017 Step up: digits form a decimal ripple-carry chain; a digit at 9 with carry-in goes to 0 and carries out.
REQ-018 Up wrap: if Q==NSTOP in COUNT with en=1, next Q=0, regardless of the BCD carry chain.
REQ-019 tc SHALL be 1 iff state==COUNT, en=1, load=0, and Q is the terminal value (NSTOP up, 0 down).
REQ-020 Load in COUNT or PAUSE has priority over step: Q<=din on the edge; the state is unchanged.
REQ-021 If any din nibble >9 on load: Q is unchanged, err=1 for the next cycle; otherwise err=0.
REQ-022 A load value greater than NSTOP is accepted.
REQ-023 When Q>NSTOP, up-counting continues through the decimal chain to the all-9s wrap to 0, then resumes the NSTOP rule.
REQ-024 Latency: Q changes one edge after the enabling condition; no internal pipelining.

Reset
REQ-025 reset=0 SHALL immediately set state=INIT, Q=0, err=0; tc=0 follows combinationally.
REQ-026 Reset asserted mid-count aborts with no residual carry; after release, INIT lasts one cycle before COUNT.

Configuration
REQ-027 Macro CNT_BCD_DOWN_EN defined: port up exists; with up=0, a step decrements with decimal borrow (digit 0 -> 9, borrow out), and Q==0 wraps to NSTOP.
REQ-028 Macro CNT_BCD_DOWN_EN undefined: no up port, up-count only, no borrow logic synthesised.

Structure
REQ-029 Shared package cnt_bcd_pkg holds the state encodings INIT/COUNT/PAUSE and the constant BCD_MAX=4'd9.
REQ-030 Sub-module bcd_digit (one nibble, inputs ci and dir, outputs next digit and co) SHALL be instantiated NDIG times via generate.

Verification
REQ-031 NDIG=2, NSTOP=8'h59, en=1 after reset release: Q goes 00 (INIT), 00, 01..59, then 00; tc=1 only while Q=59.
REQ-032 NDIG=4, load din=16'h0999 in PAUSE, then en=1: next Q=16'h1000, carry through three digits.
REQ-033 Load din=8'h3A: Q unchanged, err=1 for exactly one cycle.
REQ-034 Toggle en 1,0,1 in COUNT at Q=05: states go COUNT, PAUSE, COUNT; Q stays 05 for two cycles, then 06.
REQ-035 Reset pulled low at Q=37: Q=0 immediately, before the next clock; after release, INIT for one cycle, then the count restarts at 00.
REQ-036 With CNT_BCD_DOWN_EN, up=0, NSTOP=8'h59, load 8'h10: Q goes 09, 08 .. 00, then 59; tc=1 at Q=00.
